// File: rtl/menor_stream_pkg.sv
// Shared definitions for the menor_stream min-finder: default sizes and FSM state encoding.
package menor_stream_pkg;

  localparam int MENOR_WIDTH_DEF = 8;
  localparam int MENOR_N_DEF     = 4;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/menor_stream_if.sv
// Handshake bundle for menor_stream: sample input side and result output side.
// out_max exists only when MENOR_MAX_EN is defined.
interface menor_stream_if
  import menor_stream_pkg::*;
#(
  parameter int WIDTH = MENOR_WIDTH_DEF,
  parameter int N     = MENOR_N_DEF
);
  localparam int IDX_W = $clog2(N);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [IDX_W-1:0] out_idx;
`ifdef MENOR_MAX_EN
  logic [WIDTH-1:0] out_max;
`endif

  // The min-finder block itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_min, out_idx
`ifdef MENOR_MAX_EN
    , output out_max
`endif
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_min, out_idx
`ifdef MENOR_MAX_EN
    , input out_max
`endif
  );

endinterface

// File: rtl/menor_stream_cmp.sv
// menor_cmp: combinational unsigned magnitude compare of two WIDTH-bit values.
module menor_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             gt
);

  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/menor_stream.sv
// menor_stream: groups an input sample stream into frames of N and reports
// each frame's minimum and its first index. Build option MENOR_MAX_EN adds a
// parallel running maximum on out_max.
module menor_stream
  import menor_stream_pkg::*;
#(
  parameter int WIDTH = MENOR_WIDTH_DEF,
  parameter int N     = MENOR_N_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  menor_stream_if.slave  bus
);

  localparam int               IDX_W    = $clog2(N);
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] CNT_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] CNT_ONE  = IDX_W'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [IDX_W-1:0] cnt_r;
  logic [WIDTH-1:0] min_r;
  logic [IDX_W-1:0] idx_r;
  logic             in_ready_s;
  logic             accept_s;
  logic             first_s;
  logic             min_lt_s;
  logic             min_gt_s;
  logic             unused_s;

  // Ready depends on state alone, so the producer never sees a combinational path.
  assign in_ready_s = (state_r == S_COLLECT);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign first_s    = (cnt_r == CNT_ZERO);

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == S_HOLD);
  assign bus.out_min   = min_r;
  assign bus.out_idx   = idx_r;

  menor_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a  (bus.in_data),
    .b  (min_r),
    .lt (min_lt_s),
    .gt (min_gt_s)
  );

`ifdef MENOR_MAX_EN
  logic [WIDTH-1:0] max_r;
  logic             max_lt_s;
  logic             max_gt_s;

  menor_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a  (bus.in_data),
    .b  (max_r),
    .lt (max_lt_s),
    .gt (max_gt_s)
  );

  assign bus.out_max = max_r;
  assign unused_s    = min_gt_s ^ max_lt_s;

  // Running maximum: first sample of a frame loads, later samples replace only if strictly larger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      if (first_s || max_gt_s) begin
        max_r <= bus.in_data;
      end
    end
  end
`else
  assign unused_s = min_gt_s;
`endif

  // FSM next state: leave COLLECT on the last sample of a frame, leave HOLD on result handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_COLLECT: begin
        if (bus.in_valid && (cnt_r == CNT_LAST)) begin
          state_nxt_s = S_HOLD;
        end else begin
          state_nxt_s = S_COLLECT;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_nxt_s = S_COLLECT;
        end else begin
          state_nxt_s = S_HOLD;
        end
      end
      default: state_nxt_s = S_COLLECT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_COLLECT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame position counter; advances only on accepted samples and wraps after the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
    end else if (accept_s) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // Running minimum and its index; strict compare keeps the earliest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_r <= {WIDTH{1'b0}};
      idx_r <= CNT_ZERO;
    end else if (accept_s) begin
      if (first_s) begin
        min_r <= bus.in_data;
        idx_r <= CNT_ZERO;
      end else if (min_lt_s) begin
        min_r <= bus.in_data;
        idx_r <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_menor_stream.sv
// Self-checking bench for menor_stream. A frame-level model (queue of accepted
// samples, min/first-index/max computed per completed frame) is compared
// against the DUT on every falling edge; literal expectations pin the model.
// Define MENOR_MAX_EN to also check out_max.
module tb_menor_stream;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // Model state
  int  frame_q[$];
  bit  m_hold = 1'b0;
  int  m_min  = 0;
  int  m_idx  = 0;
  int  m_max  = 0;
  bit  run_chk = 1'b0;

  menor_stream_if #(.WIDTH(WIDTH), .N(N)) bus ();

  menor_stream #(.WIDTH(WIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame result from the list of accepted samples.
  task automatic finish_frame();
    int mn;
    int mx;
    mn = frame_q[0];
    mx = frame_q[0];
    foreach (frame_q[i]) begin
      if (frame_q[i] < mn) mn = frame_q[i];
      if (frame_q[i] > mx) mx = frame_q[i];
    end
    m_idx = -1;
    foreach (frame_q[i]) begin
      if (m_idx < 0 && frame_q[i] == mn) m_idx = i;
    end
    m_min  = mn;
    m_max  = mx;
    m_hold = 1'b1;
    frame_q.delete();
  endtask

  // One clock cycle of stimulus, entered and left at posedge+1.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r);
    bit acc;
    bit take;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    acc  = v && !m_hold;
    take = m_hold && r;
    @(posedge clk);
    #1;
    if (acc) begin
      frame_q.push_back(int'(d));
      if (frame_q.size() == N) finish_frame();
    end else if (take) begin
      m_hold = 1'b0;
    end
  endtask

  // Send a full frame one sample per cycle.
  task automatic frame4(input int a, input int b, input int c, input int e, input bit r);
    cycle(1'b1, 8'(a), r);
    cycle(1'b1, 8'(b), r);
    cycle(1'b1, 8'(c), r);
    cycle(1'b1, 8'(e), r);
  endtask

  // Literal expectation for the result currently held.
  task automatic lit(input string name, input int exp_min, input int exp_idx);
    chk({name, "_valid"}, int'(bus.out_valid), 1);
    chk({name, "_min"},   int'(bus.out_min), exp_min);
    chk({name, "_idx"},   int'(bus.out_idx), exp_idx);
    chk({name, "_mdl"},   m_min * 16 + m_idx, exp_min * 16 + exp_idx);
  endtask

  // Per-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (run_chk && rst_n) begin
      chk("cyc_in_ready",  int'(bus.in_ready),  int'(!m_hold));
      chk("cyc_out_valid", int'(bus.out_valid), int'(m_hold));
      if (m_hold) begin
        chk("cyc_out_min", int'(bus.out_min), m_min);
        chk("cyc_out_idx", int'(bus.out_idx), m_idx);
`ifdef MENOR_MAX_EN
        chk("cyc_out_max", int'(bus.out_max), m_max);
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready",  int'(bus.in_ready),  1);
    chk("rst_out_min",   int'(bus.out_min),   0);
    chk("rst_out_idx",   int'(bus.out_idx),   0);
`ifdef MENOR_MAX_EN
    chk("rst_out_max",   int'(bus.out_max),   0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_chk = 1'b1;

    // 1: basic frame, result the cycle after the 4th accept
    frame4(5, 6, 7, 3, 1'b1);
    lit("t1", 3, 3);
    cycle(1'b0, 8'd0, 1'b1);

    // 2: ties and extremes
    frame4(4, 4, 9, 4, 1'b1);
    lit("t2_tie", 4, 0);
    cycle(1'b0, 8'd0, 1'b1);
    frame4(255, 0, 0, 255, 1'b1);
    lit("t2_ext", 0, 1);
    cycle(1'b0, 8'd0, 1'b1);
    frame4(0, 0, 0, 0, 1'b1);
    lit("t2_zero", 0, 0);
    cycle(1'b0, 8'd0, 1'b1);
    frame4(255, 255, 255, 255, 1'b1);
    lit("t2_ones", 255, 0);
    cycle(1'b0, 8'd0, 1'b1);

    // 3: consumer stalls; HOLD ignores offered samples
    frame4(10, 6, 7, 20, 1'b0);
    lit("t3", 6, 1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'd0, 1'b0);
    lit("t3_held", 6, 1);
    cycle(1'b0, 8'd0, 1'b1);
    chk("t3_in_ready", int'(bus.in_ready), 1);

    // 4: valid gaps; unaccepted data (0) must not count
    cycle(1'b1, 8'd9, 1'b1);
    cycle(1'b0, 8'd0, 1'b1);
    cycle(1'b0, 8'd0, 1'b1);
    cycle(1'b1, 8'd2, 1'b1);
    cycle(1'b1, 8'd8, 1'b1);
    cycle(1'b0, 8'd0, 1'b1);
    chk("t4_not_yet", int'(bus.out_valid), 0);
    cycle(1'b1, 8'd1, 1'b1);
    lit("t4", 1, 3);
    cycle(1'b0, 8'd0, 1'b1);

    // 5: asynchronous reset mid-frame
    cycle(1'b1, 8'd9, 1'b1);
    cycle(1'b1, 8'd4, 1'b1);
    cycle(1'b1, 8'd2, 1'b1);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_min",   int'(bus.out_min),   0);
    chk("t5_rst_valid", int'(bus.out_valid), 0);
    chk("t5_rst_ready", int'(bus.in_ready),  1);
    rst_n = 1'b1;
    frame_q.delete();
    m_hold = 1'b0;
    frame4(8, 7, 6, 5, 1'b1);
    lit("t5", 5, 3);
    cycle(1'b0, 8'd0, 1'b1);

    // 6: frame with distinct min and max
    frame4(10, 15, 7, 20, 1'b1);
    lit("t6", 7, 2);
    chk("t6_mdl_max", m_max, 20);
`ifdef MENOR_MAX_EN
    chk("t6_max", int'(bus.out_max), 20);
`endif
    cycle(1'b0, 8'd0, 1'b1);
    cycle(1'b0, 8'd0, 1'b0);

    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
